// File: rtl/req_xbar_credit_sched.sv
// req_xbar_credit_sched: N-requester to 4-port crossbar. Each output port has
// its own round-robin arbiter and its own downstream credit counter.
//   clk, rst_n      : clock and synchronous active-low reset
//   in_vld/in_pld/in_select/in_rdy : per-requester request, payload, target
//                     port and combinational grant (transfer when vld & rdy)
//   out_vld/out_pld : per-port issue, one cycle after the grant
//   credit_ret      : per-port credit return, one credit per cycle
//   credit_cnt      : per-port credit count
//   credit_err      : per-port sticky flag for a return while already full

// req_xbar_port: one output port. It arbitrates among the requesters that
// target this port, issues the winner's payload and tracks the port's credits.
//   grant is one-hot over requesters and is combinational.
module req_xbar_port #(
    parameter int N          = 8,
    parameter int PLD_WIDTH  = 32,
    parameter int CREDIT_MAX = 4,
    parameter int PORT       = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N-1:0]                   in_vld,
    input  logic [N-1:0][1:0]              in_select,
    input  logic [N-1:0][PLD_WIDTH-1:0]    in_pld,
    input  logic                           credit_ret,
    output logic [N-1:0]                   grant,
    output logic                           out_vld,
    output logic [PLD_WIDTH-1:0]           out_pld,
    output logic [3:0]                     credit_cnt,
    output logic                           credit_err
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [N-1:0]  cand;
    logic [PW-1:0] idx;
    logic [PW-1:0] win_idx;
    logic          found;
    logic          grant_en;

    always_comb begin
        for (int i = 0; i < N; i++)
            cand[i] = in_vld[i] && (in_select[i] == 2'(PORT));
    end

    // Scan upward from ptr+1 with wrap; the first candidate found wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && cand[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Reset gating keeps in_rdy low while rst_n is asserted.
    assign grant_en = found && (credit_cnt != 4'd0) && rst_n;

    always_comb begin
        grant = '0;
        if (grant_en)
            grant[win_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr        <= PW'(N - 1);
            out_vld    <= 1'b0;
            out_pld    <= '0;
            credit_cnt <= 4'(CREDIT_MAX);
            credit_err <= 1'b0;
        end else begin
            out_vld <= grant_en;
            if (grant_en) begin
                out_pld <= in_pld[win_idx];
                ptr     <= win_idx;
            end
            // Grant and return together cancel out.
            case ({grant_en, credit_ret})
                2'b10: credit_cnt <= credit_cnt - 4'd1;
                2'b01: begin
                    if (credit_cnt == 4'(CREDIT_MAX))
                        credit_err <= 1'b1;
                    else
                        credit_cnt <= credit_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

module req_xbar_credit_sched #(
    parameter int N          = 8,
    parameter int PLD_WIDTH  = 32,
    parameter int CREDIT_MAX = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N-1:0]                   in_vld,
    input  logic [N-1:0][PLD_WIDTH-1:0]    in_pld,
    input  logic [N-1:0][1:0]              in_select,
    output logic [N-1:0]                   in_rdy,
    output logic [3:0]                     out_vld,
    output logic [3:0][PLD_WIDTH-1:0]      out_pld,
    input  logic [3:0]                     credit_ret,
    output logic [3:0][3:0]                credit_cnt,
    output logic [3:0]                     credit_err
);
    logic [3:0][N-1:0] gnt;

    for (genvar p = 0; p < 4; p++) begin : g_port
        req_xbar_port #(
            .N          (N),
            .PLD_WIDTH  (PLD_WIDTH),
            .CREDIT_MAX (CREDIT_MAX),
            .PORT       (p)
        ) u_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_vld     (in_vld),
            .in_select  (in_select),
            .in_pld     (in_pld),
            .credit_ret (credit_ret[p]),
            .grant      (gnt[p]),
            .out_vld    (out_vld[p]),
            .out_pld    (out_pld[p]),
            .credit_cnt (credit_cnt[p]),
            .credit_err (credit_err[p])
        );
    end

    // A requester targets exactly one port, so at most one grant row can hit it.
    always_comb begin
        in_rdy = '0;
        for (int p = 0; p < 4; p++)
            in_rdy = in_rdy | gnt[p];
    end
endmodule

// File: tb/tb_req_xbar_credit_sched.sv
// tb_req_xbar_credit_sched: directed scenarios followed by random traffic,
// every cycle compared against a reference model of the arbitration and
// credit rules.
module tb_req_xbar_credit_sched;
    localparam int N  = 8;
    localparam int PW = 32;
    localparam int CM = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          in_vld;
    logic [N-1:0][PW-1:0]  in_pld;
    logic [N-1:0][1:0]     in_select;
    logic [N-1:0]          in_rdy;
    logic [3:0]            out_vld;
    logic [3:0][PW-1:0]    out_pld;
    logic [3:0]            credit_ret;
    logic [3:0][3:0]       credit_cnt;
    logic [3:0]            credit_err;

    req_xbar_credit_sched #(.N(N), .PLD_WIDTH(PW), .CREDIT_MAX(CM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_pld     (in_pld),
        .in_select  (in_select),
        .in_rdy     (in_rdy),
        .out_vld    (out_vld),
        .out_pld    (out_pld),
        .credit_ret (credit_ret),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: last winner, credits, sticky error, expected outputs.
    int          m_ptr [4];
    int          m_cnt [4];
    bit          m_err [4];
    bit          m_vld [4];
    logic [PW-1:0] m_pld [4];
    int          win   [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < 4; p++) begin
            m_ptr[p] = N - 1;
            m_cnt[p] = CM;
            m_err[p] = 1'b0;
            m_vld[p] = 1'b0;
            m_pld[p] = '0;
        end
    endfunction

    // Winner per port: the candidate at the smallest circular distance past ptr.
    function automatic void model_arb();
        for (int p = 0; p < 4; p++) begin
            int best;
            best   = N + 1;
            win[p] = -1;
            if (rst_n === 1'b1 && m_cnt[p] > 0) begin
                for (int i = 0; i < N; i++) begin
                    int d;
                    d = (i - m_ptr[p] - 1 + 2 * N) % N;
                    if (in_vld[i] && int'(in_select[i]) == p && d < best) begin
                        best   = d;
                        win[p] = i;
                    end
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_rdy();
        logic [N-1:0] r;
        r = '0;
        for (int p = 0; p < 4; p++)
            if (win[p] >= 0) r[win[p]] = 1'b1;
        return r;
    endfunction

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        model_arb();
        chk("in_rdy", 64'(in_rdy), 64'(exp_rdy()));
        if (rst_n !== 1'b1) begin
            model_reset();
        end else begin
            for (int p = 0; p < 4; p++) begin
                bit g;
                g = (win[p] >= 0);
                m_vld[p] = g;
                if (g) begin
                    m_pld[p] = in_pld[win[p]];
                    m_ptr[p] = win[p];
                end
                if (g && !credit_ret[p])
                    m_cnt[p] = m_cnt[p] - 1;
                else if (!g && credit_ret[p]) begin
                    if (m_cnt[p] == CM) m_err[p] = 1'b1;
                    else m_cnt[p] = m_cnt[p] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("out_vld[%0d]", p), 64'(out_vld[p]), 64'(m_vld[p]));
            chk($sformatf("out_pld[%0d]", p), 64'(out_pld[p]), 64'(m_pld[p]));
            chk($sformatf("credit_cnt[%0d]", p), 64'(credit_cnt[p]), 64'(m_cnt[p]));
            chk($sformatf("credit_err[%0d]", p), 64'(credit_err[p]), 64'(m_err[p]));
        end
        @(negedge clk);
    endtask

    task automatic clr();
        in_vld     = '0;
        in_select  = '0;
        credit_ret = '0;
        for (int i = 0; i < N; i++) in_pld[i] = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int ord [3];
        logic [PW-1:0] pl [4];
        model_reset();
        rst_n = 1'b0;
        clr();
        @(negedge clk);
        do_reset();

        // Round robin among 0,3,5 on port 2 with a credit returned each issue.
        ord[0] = 0; ord[1] = 3; ord[2] = 5;
        in_vld = 8'b0010_1001;
        in_select[0] = 2'd2; in_select[3] = 2'd2; in_select[5] = 2'd2;
        credit_ret = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            #1 chk("rr_order", 64'(in_rdy), 64'(1) << ord[k % 3]);
            in_pld[ord[k % 3]] = $urandom;
            cycle();
            chk("rr_out_vld2", 64'(out_vld[2]), 64'(1));
        end

        // Credit exhaustion on port 0, then a single returned credit.
        do_reset();
        in_vld[1] = 1'b1; in_select[1] = 2'd0;
        for (int k = 0; k < 4; k++) begin
            #1 chk("drain_rdy", 64'(in_rdy[1]), 64'(1));
            cycle();
        end
        #1 chk("empty_rdy", 64'(in_rdy[1]), 64'(0));
        chk("empty_cnt", 64'(credit_cnt[0]), 64'(0));
        cycle();
        credit_ret[0] = 1'b1;
        #1 chk("ret_cycle_rdy", 64'(in_rdy[1]), 64'(0));
        cycle();
        credit_ret[0] = 1'b0;
        #1 chk("after_ret_rdy", 64'(in_rdy[1]), 64'(1));
        cycle();
        chk("after_ret_issue", 64'(out_vld[0]), 64'(1));
        #1 chk("after_ret_empty", 64'(in_rdy[1]), 64'(0));
        cycle();
        chk("after_ret_quiet", 64'(out_vld[0]), 64'(0));

        // Four requesters to four ports in one cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_vld[i] = 1'b1; in_select[i] = 2'(i);
            pl[i] = $urandom; in_pld[i] = pl[i];
        end
        #1 chk("par_rdy", 64'(in_rdy), 64'h0F);
        cycle();
        chk("par_vld", 64'(out_vld), 64'hF);
        for (int p = 0; p < 4; p++)
            chk($sformatf("par_pld[%0d]", p), 64'(out_pld[p]), 64'(pl[p]));

        // Grant plus return cancels; return while full sets the error.
        do_reset();
        in_vld[2] = 1'b1; in_select[2] = 2'd3;
        credit_ret = 4'b1000;
        cycle();
        chk("cancel_cnt3", 64'(credit_cnt[3]), 64'(CM));
        in_vld = '0;
        cycle();
        chk("over_err3", 64'(credit_err[3]), 64'(1));
        chk("over_cnt3", 64'(credit_cnt[3]), 64'(CM));
        credit_ret = '0;

        // Reset after two grants on port 1.
        do_reset();
        in_vld[2] = 1'b1; in_select[2] = 2'd1;
        in_vld[6] = 1'b1; in_select[6] = 2'd1;
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        chk("rst_vld1", 64'(out_vld[1]), 64'(0));
        chk("rst_cnt1", 64'(credit_cnt[1]), 64'(CM));
        rst_n = 1'b1;
        #1 chk("rst_first_grant", 64'(in_rdy), 64'(1) << 2);
        cycle();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            rst_n     = ($urandom_range(63) != 0);
            in_vld    = 8'($urandom);
            in_select = 16'($urandom);
            for (int i = 0; i < N; i++) in_pld[i] = $urandom;
            for (int p = 0; p < 4; p++) credit_ret[p] = ($urandom_range(2) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
